add_pipe: RTL and testbench
===========================

ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 SHALL have parameter: NUM_SLICES, default 4, number of 4-bit carry-lookahead slices; legal 1..8; operand width W = 4*NUM_SLICES.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 SHALL have port: in_valid  input  1  operand set offered.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have ports: a, b  input  W  unsigned/two's-complement operands; cin  input  1  carry in.
REQ-007 SHALL have port: out_valid  output  1  result held on outputs.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-009 SHALL have ports: sum  output  W; cout  output  1 carry out of MSB; ovf  output  1 signed overflow.
REQ-010 SHALL have port: busy  output  1  high when any pipeline stage holds a valid transaction.

Function
REQ-011 SHALL implement NUM_SLICES register stages; stage k adds slice k (bits 4k+3:4k) using the carry registered by stage k-1 (stage 0 uses cin).
REQ-012 SHALL carry the unprocessed upper operand bits and the already-computed lower sum bits forward, registered, alongside each stage's valid bit and carry.
REQ-013 SHALL define advance = !out_valid | out_ready; all stages shift together only when advance = 1 (global stall).
REQ-014 SHALL drive in_ready = advance combinationally; transfer in occurs on an edge where in_valid & in_ready.
REQ-015 SHALL shift a bubble (valid = 0) into stage 0 on advance when in_valid = 0; bubbles are not compressed.
REQ-016 SHALL present a result accepted at edge t as out_valid = 1 after edge t+NUM_SLICES-1 (latency NUM_SLICES cycles, throughput 1/cycle).
REQ-017 SHALL hold sum, cout, ovf, out_valid stable while out_valid & !out_ready.
REQ-018 SHALL permit simultaneous input accept and output handoff in one cycle with no loss or duplication.
REQ-019 SHALL compute sum = (a + b + cin) mod 2^W, cout = bit W of that sum, ovf = carry into MSB XOR cout.
REQ-020 SHALL deliver results in acceptance order.
REQ-021 SHALL drive busy = OR of all stage valid bits (including output stage).

Reset
REQ-022 SHALL, while rst_n = 0, clear all valid bits, carries and data registers; out_valid = 0, sum = 0, cout = 0, ovf = 0, busy = 0.
REQ-023 SHALL discard all in-flight transactions on reset assertion mid-operation; none appear after release.
REQ-024 SHALL drive in_ready = 1 during and immediately after reset.

Structure
REQ-025 SHALL place SLICE_W = 4 and a result struct typedef (sum, cout, ovf) in shared package add_pipe_pkg.
REQ-026 SHALL instantiate the existing CLA4 slice (a[3:0], b[3:0], cin, s[3:0], cout) once per stage via generate; no other sub-module.
REQ-027 SHALL expose the carry into the MSB from the final CLA4 slice internally for ovf (final slice recomputes it from its P/G or the team extends CLA4 with a c3 output in its own change).

Verification (NUM_SLICES = 4)
REQ-028 SHALL cover: a=0xFFFF, b=0x0001, cin=0 accepted at edge 1 -> out_valid after edge 4, sum=0x0000, cout=1, ovf=0.
REQ-029 SHALL cover: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
REQ-030 SHALL cover: 6 back-to-back transfers, out_ready=1 -> 6 results on 6 consecutive cycles, in order, in_ready never low.
REQ-031 SHALL cover: pipeline full, out_ready=0 for 3 cycles -> in_ready=0, outputs frozen, busy=1; on out_ready=1 all 4 results drain in order, none lost.
REQ-032 SHALL cover: rst_n pulsed low with 3 transactions in flight -> out_valid=0, busy=0 immediately; no result emerges in the following 8 cycles with in_valid=0.

Source files
------------

// File: rtl/add_pipe_pkg.sv
// Shared constants, result type and carry helper for the pipelined
// carry-lookahead adder.
package add_pipe_pkg;

    localparam int unsigned SLICE_W    = 4;
    localparam int unsigned MAX_SLICES = 8;
    localparam int unsigned MAX_W      = SLICE_W * MAX_SLICES;

    // Sized for the widest legal configuration; narrower builds use the low bits.
    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic             cout;
        logic             ovf;
    } add_res_t;

    // Carry into bit 3 of a 4-bit slice, rebuilt from the lower P/G terms.
    function automatic logic msb_carry(
        input logic [2:0] a,
        input logic [2:0] b,
        input logic       cin
    );
        logic [2:0] p;
        logic [2:0] g;
        p = a ^ b;
        g = a & b;
        return g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
    endfunction

endpackage

// File: rtl/add_pipe_cla4.sv
// Existing 4-bit carry-lookahead slice: one combinational add of a/b/cin.
module cla4
    import add_pipe_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic               c1;
    logic               c2;
    logic               c3;

    assign p = a ^ b;
    assign g = a & b;

    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/add_pipe.sv
// Pipelined adder: one CLA4 slice per register stage, ripple carry registered
// between stages, valid/ready handshake with a global stall.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int unsigned NUM_SLICES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] a,
    input  logic [SLICE_W*NUM_SLICES-1:0] b,
    input  logic                          cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] sum,
    output logic                          cout,
    output logic                          ovf,
    output logic                          busy
);

    localparam int unsigned W    = SLICE_W * NUM_SLICES;
    localparam int unsigned LAST = NUM_SLICES - 1;

    logic                  advance;

    logic [NUM_SLICES-1:0] vld_q;
    logic [NUM_SLICES-1:0] c_q;
    logic [W-1:0]          a_q [NUM_SLICES];
    logic [W-1:0]          b_q [NUM_SLICES];
    logic [W-1:0]          s_q [NUM_SLICES];
    logic                  ovf_q;

    logic [NUM_SLICES-1:0] vld_d;
    logic [NUM_SLICES-1:0] c_d;
    logic [W-1:0]          a_d [NUM_SLICES];
    logic [W-1:0]          b_d [NUM_SLICES];
    logic [W-1:0]          s_d [NUM_SLICES];
    logic                  ovf_d;

    logic [NUM_SLICES-1:0] ci;
    logic [W-1:0]          sp  [NUM_SLICES];
    logic [SLICE_W-1:0]    slice_s [NUM_SLICES];
    logic                  msb_c;

    add_res_t              res;
    logic                  unused_ok;

    assign advance  = !vld_q[LAST] || out_ready;
    assign in_ready = advance;

    // Operands travel whole; stage k fills its own slice of the partial sum.
    for (genvar k = 0; k < NUM_SLICES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_d[k]   = a;
            assign b_d[k]   = b;
            assign ci[k]    = cin;
            assign sp[k]    = '0;
            assign vld_d[k] = in_valid;
        end else begin : g_body
            assign a_d[k]   = a_q[k-1];
            assign b_d[k]   = b_q[k-1];
            assign ci[k]    = c_q[k-1];
            assign sp[k]    = s_q[k-1];
            assign vld_d[k] = vld_q[k-1];
        end

        cla4 u_cla4 (
            .a    (a_d[k][SLICE_W*k +: SLICE_W]),
            .b    (b_d[k][SLICE_W*k +: SLICE_W]),
            .cin  (ci[k]),
            .s    (slice_s[k]),
            .cout (c_d[k])
        );

        assign s_d[k] = sp[k] | (W'(slice_s[k]) << (SLICE_W * k));
    end

    assign msb_c = msb_carry(a_d[LAST][W-2 -: 3], b_d[LAST][W-2 -: 3], ci[LAST]);
    assign ovf_d = msb_c ^ c_d[LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int unsigned k = 0; k < NUM_SLICES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int unsigned k = 0; k < NUM_SLICES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    always_comb begin
        res             = '0;
        res.sum[W-1:0]  = s_q[LAST];
        res.cout        = c_q[LAST];
        res.ovf         = ovf_q;
    end

    assign sum       = res.sum[W-1:0];
    assign cout      = res.cout;
    assign ovf       = res.ovf;
    assign out_valid = vld_q[LAST];
    assign busy      = |vld_q;

    // Final-stage operand copies have no consumer.
    assign unused_ok = ^{a_q[LAST], b_q[LAST], res.sum};

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe with NUM_SLICES = 4.
module tb_add_pipe;

    localparam int unsigned NS = 4;
    localparam int unsigned W  = 4 * NS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;

    always #5 clk = ~clk;

    add_pipe #(.NUM_SLICES(NS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t         m;
        logic [W:0]   t;
        t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        m.sum  = t[W-1:0];
        m.cout = t[W];
        m.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return m;
    endfunction

    // Inputs are stable from posedge+1 to the next posedge, so the negedge
    // view is exactly what the next edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum",  32'(sum),  32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("ovf",  32'(ovf),  32'(e.ovf));
                    pops++;
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, cin));
        end
    end

    task automatic offer(input logic v);
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom_range(0, 1));
        in_valid = v;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check("drain_sb",   32'(sb.size()), 32'd0);
        check("drain_busy", 32'(busy),      32'd0);
    endtask

    task automatic run_one(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        @(posedge clk); #1;
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < int'(NS); i++) begin
            @(negedge clk);
            check("latency_valid", 32'(out_valid), (i == int'(NS) - 1) ? 32'd1 : 32'd0);
        end
        check("dir_sum",  32'(sum),  32'(es));
        check("dir_cout", 32'(cout), 32'(ec));
        check("dir_ovf",  32'(ovf),  32'(eo));
    endtask

    initial begin
        logic ov [12];
        int   first;
        int   last;
        int   ones;
        int   pops_before;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;

        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_one(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        run_one(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Back-to-back stream with the consumer always ready.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i < 6) offer(1'b1);
            else       in_valid = 1'b0;
            @(negedge clk);
            if (i < 6) check("b2b_in_ready", 32'(in_ready), 32'd1);
            ov[i] = out_valid;
        end
        first = -1; last = -1; ones = 0;
        for (int i = 0; i < 12; i++) begin
            if (ov[i]) begin
                ones++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("b2b_count",  32'(ones),             32'd6);
        check("b2b_contig", 32'(last - first + 1), 32'd6);

        // Fill the pipe against a stalled consumer, hold, then drain.
        out_ready = 1'b0;
        for (int j = 0; j < int'(NS); j++) begin
            @(posedge clk); #1;
            offer(1'b1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_busy",      32'(busy),      32'd1);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            if (sb.size() != 0) check("stall_sum", 32'(sum), 32'(sb[0].sum));
            else                check("stall_sb_size", 32'(sb.size()), 32'(NS));
        end
        pops_before = pops;
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();
        check("stall_drained", 32'(pops - pops_before), 32'(NS));

        // Reset with three transactions in flight.
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            offer(1'b1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_rel_ready", 32'(in_ready), 32'd1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("mid_rst_no_out", 32'(out_valid), 32'd0);
        end

        // Random traffic with random consumer back-pressure.
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            offer($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
